// File: rtl/alu_pkg.sv
// Shared ALU definitions: result/tag widths and the op-field encoding of alu_control.
// The FIFO treats tags as opaque; the decode helpers are for consumers and benches.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;

    // alu_control[3:1]; alu_control[0] selects a constant 1 as the second operand
    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpMul = 3'd2,
        OpShr = 3'd3,
        OpShl = 3'd4
    } alu_op_e;

    function automatic alu_op_e op_field(input logic [OP_W-1:0] tag);
        return alu_op_e'(tag[OP_W-1:1]);
    endfunction

    function automatic logic op_const_one(input logic [OP_W-1:0] tag);
        return tag[0];
    endfunction

endpackage

// File: rtl/alu_fifo_mem.sv
// Entry storage for the result FIFO: one synchronous write port, one asynchronous read port.
// Deliberately unreset; validity is tracked by the occupancy level in the parent.
module alu_fifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 37,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// First-word-fall-through buffer for ALU results tagged with their op code and a zero flag.
// The producer cannot stall, so writes arriving while full are dropped and counted.
module alu_result_fifo #(
    parameter int unsigned DATA_W = alu_pkg::DATA_W,
    parameter int unsigned OP_W   = alu_pkg::OP_W,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [OP_W-1:0]          in_op,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [OP_W-1:0]          out_op,
    output logic                     out_zero,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         drop_count,
    input  logic                     clr_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = OP_W + 1 + DATA_W;
    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [CNT_W-1:0] r_drop;

    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic [EW-1:0] w_wr_entry;
    logic [EW-1:0] w_rd_entry;

    // Ready depends only on registered level, so a full FIFO refuses even when popping.
    assign in_ready  = (r_level != LVL_FULL);
    assign out_valid = (r_level != '0);

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;
    assign w_drop = in_valid & ~in_ready;

    assign w_wr_entry = {in_op, (in_data == '0), in_data};

    alu_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_drop   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // Clear wins over a coincident drop
            if (clr_drop) begin
                r_drop <= '0;
            end else if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    assign out_data   = out_valid ? w_rd_entry[DATA_W-1:0]     : '0;
    assign out_zero   = out_valid ? w_rd_entry[DATA_W]         : 1'b0;
    assign out_op     = out_valid ? w_rd_entry[EW-1:DATA_W+1]  : '0;
    assign level      = r_level;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized and directed bench for alu_result_fifo against a queue-based reference model.
module tb_alu_result_fifo;
    import alu_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_MAX = 255;

    typedef struct packed {
        logic [3:0]  op;
        logic        z;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_op;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_op;
    logic        out_zero;
    logic        out_ready;
    logic [3:0]  level;
    logic [7:0]  drop_count;
    logic        clr_drop;

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];
    int   mdrop = 0;

    always #5 clk = ~clk;

    alu_result_fifo #(
        .DATA_W (32),
        .OP_W   (4),
        .DEPTH  (DEPTH),
        .CNT_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_op      (in_op),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_op     (out_op),
        .out_zero   (out_zero),
        .out_ready  (out_ready),
        .level      (level),
        .drop_count (drop_count),
        .clr_drop   (clr_drop)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] op,
                         input logic rdy, input logic clr);
        in_valid  = v;
        in_data   = d;
        in_op     = op;
        out_ready = rdy;
        clr_drop  = clr;
    endtask

    // Compare outputs with the model, then advance the model and the DUT by one edge.
    task automatic step();
        ent_t head;
        bit   m_valid;
        bit   m_ready;
        #2;
        m_valid = (q.size() != 0);
        m_ready = (q.size() != DEPTH);
        head    = m_valid ? q[0] : '0;
        check_eq("out_valid", out_valid, m_valid);
        check_eq("in_ready", in_ready, m_ready);
        check_eq("level", level, q.size());
        check_eq("out_data", out_data, head.d);
        check_eq("out_op", out_op, head.op);
        check_eq("out_zero", out_zero, head.z);
        check_eq("drop_count", drop_count, mdrop);
        if (clr_drop) mdrop = 0;
        else if (in_valid && !m_ready && mdrop < CNT_MAX) mdrop++;
        if (m_valid && out_ready) void'(q.pop_front());
        if (in_valid && m_ready) q.push_back('{op: in_op, z: (in_data == 0), d: in_data});
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        #3;
        rst = 1'b1;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_op", out_op, 0);
        check_eq("rst_out_zero", out_zero, 0);
        check_eq("rst_drop", drop_count, 0);
        q.delete();
        mdrop = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Reset mid-operation with three entries held
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h10 + i, 4'(i), 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        step();
        mid_reset();
        drive(1, 32'h5, 4'h0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        check_eq("post_rst_data", out_data, 32'h5);
        check_eq("post_rst_level", level, 1);
        drive(0, 0, 0, 1, 0);
        step();

        // Ordering
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i + 1), 4'(2 * i), 0, 0);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0);
            step();
        end

        // Full and drop: ten writes into eight slots
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'(100 + i), 4'(i), 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        #2;
        check_eq("full_level", level, 8);
        check_eq("full_in_ready", in_ready, 0);
        check_eq("full_drops", drop_count, 2);
        #0 step();
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 1, 0);
            step();
        end

        // Steady push+pop at level 4, pointers wrap past DEPTH
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(200 + i), 4'h2, 0, 0);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'(204 + i), 4'h4, 1, 0);
            step();
            check_eq("steady_level", level, 4);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0);
            step();
        end

        // Zero flag
        drive(1, 32'h0, {OpSub, 1'b1}, 0, 0);
        step();
        drive(1, 32'hFFFF_FFFF, {OpAdd, 1'b0}, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        check_eq("zero_flag_set", out_zero, 1);
        drive(0, 0, 0, 1, 0);
        step();
        check_eq("zero_flag_clr", out_zero, 0);
        step();

        // Drop counter saturation, then clear racing a drop
        drive(0, 0, 0, 0, 1);
        step();
        for (int i = 0; i < DEPTH + 300; i++) begin
            drive(1, $urandom, 4'(i), 0, 0);
            step();
        end
        check_eq("drop_saturated", drop_count, 255);
        drive(1, 32'h1234, 4'h1, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        check_eq("drop_cleared", drop_count, 0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(0, 0, 0, 1, 0);
            step();
        end

        // Random traffic with alternating backpressure phases
        for (int i = 0; i < 600; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 50) % 2 == 0) ? 80 : 25;
            drive(($urandom % 4) != 0,
                  (($urandom % 8) == 0) ? 32'h0 : $urandom,
                  4'($urandom % 16),
                  ($urandom % 100) < rdy_pct,
                  ($urandom % 64) == 0);
            step();
        end
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH + 1; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the ALU; captures each ALU result r together with the 4-bit alu_control code that produced it.
- Buffers results in a small first-word-fall-through FIFO and hands them to a consumer over a valid/ready handshake.
- The ALU sequencer is free-running and cannot be stalled, so results arriving while the FIFO is full are dropped and counted.
- Each entry also carries a stored zero flag.

Parameters:
- DATA_W, 32, result width; must match the ALU r width.
- OP_W, 4, width of the op tag; must match alu_control.
- DEPTH, 8, number of FIFO entries; power of two, at least 2.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  the ALU result on in_data/in_op is valid this cycle.
- in_data  in  DATA_W  ALU result r.
- in_op  in  OP_W  alu_control code for in_data.
- in_ready  out  1  FIFO can accept a write this cycle.
- out_valid  out  1  head entry is present.
- out_data  out  DATA_W  head entry data.
- out_op  out  OP_W  head entry op tag.
- out_zero  out  1  head entry data was all zeros.
- out_ready  in  1  consumer accepts the head this cycle.
- level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- drop_count  out  CNT_W  results lost while full; saturating.
- clr_drop  in  1  synchronous clear of drop_count.

Behaviour:
- Reset (asynchronous, immediate):
  - wr_ptr=0, rd_ptr=0, level=0, drop_count=0.
  - out_valid=0, in_ready=1.
  - out_data=0, out_op=0, out_zero=0.
  - Storage array is not reset.
- Write and read enables:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (level != DEPTH).
  - Depends only on registered state, never on out_ready.
  - A full FIFO refuses the push even if a pop happens in the same cycle.
- out_valid = (level != 0).
- Head outputs:
  - out_data, out_op and out_zero are driven from mem[rd_ptr] when out_valid=1.
  - All three are forced to 0 when out_valid=0.
- out_zero is computed at write time as (in_data == 0) and stored with the entry.
- Push:
  - mem[wr_ptr] <= {in_op, zero, in_data}.
  - wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- level update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Latency:
  - A push into an empty FIFO makes out_valid=1 on the next cycle. There is no same-cycle bypass.
  - A popped entry is replaced by the next entry on the following cycle.
- Simultaneous push and pop at level 1..DEPTH-1: both happen; level unchanged; ordering preserved.
- Drop counting:
  - A drop is in_valid & ~in_ready.
  - On a drop, drop_count increments and saturates at 2^CNT_W-1.
  - The dropped data is discarded.
- clr_drop:
  - Sets drop_count to 0 on the next edge.
  - Takes priority over a drop in the same cycle; that drop is not counted.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided by level, never by pointer comparison.
- out_ready while empty is ignored.
- Reset asserted mid-operation: all contents are lost immediately, outputs return to reset values, and the first push after release lands in entry 0.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W=32 and OP_W=4.
  - Op-field encodings for alu_control[3:1], used by benches to decode tags: ADD, SUB, MUL, SHR, SHL.
  - Bit 0 means "operand is constant 1".
  - This block treats the tag as opaque.
- One sub-module: alu_fifo_mem.
  - DEPTH x (OP_W+1+DATA_W) register array.
  - One synchronous write port, one asynchronous read port, no reset.
- Control (pointers, level, drop counter, output gating) lives in alu_result_fifo.

Test Plan:
- Reset: assert rst mid-cycle with level=3 -> immediately out_valid=0, level=0, in_ready=1, out_data=0; after release, push 32'h5 with op 4'h0 -> next cycle out_data=5, out_op=0, level=1.
- Ordering: with out_ready=0, push 1,2,3,4 with ops 0,2,4,6, then hold out_ready=1 -> out_data sequence 1,2,3,4 with matching ops on consecutive cycles, then out_valid=0.
- Full and drop: with out_ready=0, push 10 values 100..109 -> level=8, in_ready=0, drop_count=2; draining yields 100..107 only.
- Simultaneous push and pop at level 4 for 20 cycles with incrementing data -> level stays 4, output is strictly in order, pointers wrap cleanly past DEPTH.
- Zero flag and counter: push 0 with op 4'h3 (SUB of equal operands) -> out_zero=1; push 32'hFFFF_FFFF -> out_zero=0. Hold full with in_valid=1 for 300 cycles -> drop_count=255 (saturated). Assert clr_drop together with a drop -> drop_count=0.
